// File: rtl/buffer_write.sv
// Write-side segment allocator: draws buffer segments from a self-initialising free list,
// writes beats at {segment, offset} and publishes each completed segment with its flow ID.

module buffer_write #(
  parameter int SEGMENT_SIZE_W = 10,
  parameter int BUF_SEG_AW     = 10,
  parameter int ADDR_WIDTH     = BUF_SEG_AW + SEGMENT_SIZE_W,
  parameter int FLOWS_W        = 3,
  parameter int DATA_W         = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic [FLOWS_W-1:0]    s_tdest,
  output logic                  s_tready,
  input  logic [BUF_SEG_AW-1:0] freed_pointer,
  input  logic                  freed_pointer_valid,
  output logic                  b_wen,
  output logic [ADDR_WIDTH-1:0] b_waddr,
  output logic [DATA_W-1:0]     b_wdata,
  output logic [BUF_SEG_AW:0]   used_pointer,
  output logic                  used_pointer_valid,
  output logic [FLOWS_W-1:0]    used_pointer_flow,
  output logic [BUF_SEG_AW:0]   free_level,
  output logic                  init_done
);

  localparam int DEPTH = 1 << BUF_SEG_AW;
  localparam logic [BUF_SEG_AW:0] FULL_LEVEL = (BUF_SEG_AW+1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [BUF_SEG_AW-1:0]   init_cnt_q, init_cnt_d;
  logic                    init_phase;

  logic [BUF_SEG_AW-1:0]   fl_mem [DEPTH];
  logic [BUF_SEG_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [BUF_SEG_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [BUF_SEG_AW:0]     count_q, count_d;
  logic [BUF_SEG_AW-1:0]   rdata_q;
  logic                    push, pop;
  logic [BUF_SEG_AW-1:0]   push_data;

  logic                    pend_q, pend_d;
  logic [BUF_SEG_AW-1:0]   next_seg_q, next_seg_d;
  logic                    next_valid_q, next_valid_d;
  logic [BUF_SEG_AW-1:0]   cur_seg_q, cur_seg_d;
  logic                    cur_valid_q, cur_valid_d;
  logic [SEGMENT_SIZE_W-1:0] offset_q, offset_d;
  logic                    first_q, first_d;
  logic [FLOWS_W-1:0]      cur_flow_q, cur_flow_d;
  logic [FLOWS_W-1:0]      flow_eff;

  logic                    accept, seg_end, close, move, next_vacate;

  logic                    b_wen_q, b_wen_d;
  logic [ADDR_WIDTH-1:0]   b_waddr_q, b_waddr_d;
  logic [DATA_W-1:0]       b_wdata_q, b_wdata_d;
  logic [BUF_SEG_AW:0]     used_q, used_d;
  logic                    used_valid_q, used_valid_d;
  logic [FLOWS_W-1:0]      used_flow_q, used_flow_d;

  // Init FSM: one free-list entry per cycle, then run until the next reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == {BUF_SEG_AW{1'b1}}) state_d = ST_RUN;
    end
  end

  always_comb begin
    init_phase = (state_q == ST_INIT);
    init_done  = (state_q == ST_RUN);
  end

  assign s_tready = init_done && cur_valid_q;
  assign accept   = s_tvalid && s_tready;
  assign seg_end  = (offset_q == {SEGMENT_SIZE_W{1'b1}});
  assign close    = accept && (s_tlast || seg_end);
  assign move     = !cur_valid_q && next_valid_q;
  assign flow_eff = first_q ? s_tdest : cur_flow_q;

  // A pop is only issued when its data has a free next_seg slot to land in one cycle later.
  assign next_vacate = move || (close && next_valid_q);
  assign pop  = init_done && (count_q != '0) && !pend_q && (!next_valid_q || next_vacate);
  assign push = init_phase || (init_done && freed_pointer_valid);
  assign push_data = init_phase ? init_cnt_q : freed_pointer;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fl_mem[wr_ptr_q] <= push_data;
    if (pop)  rdata_q <= fl_mem[rd_ptr_q];
  end

  // Prefetch, offset and flow-lock next state.
  always_comb begin
    pend_d       = pop;
    next_seg_d   = next_seg_q;
    next_valid_d = next_valid_q;
    cur_seg_d    = cur_seg_q;
    cur_valid_d  = cur_valid_q;
    offset_d     = offset_q;
    first_d      = first_q;
    cur_flow_d   = cur_flow_q;

    if (next_vacate) next_valid_d = 1'b0;
    if (pend_q) begin
      next_valid_d = 1'b1;
      next_seg_d   = rdata_q;
    end

    if (move) begin
      cur_valid_d = 1'b1;
      cur_seg_d   = next_seg_q;
    end else if (close) begin
      if (next_valid_q) cur_seg_d = next_seg_q;
      else              cur_valid_d = 1'b0;
    end

    if (close)       offset_d = '0;
    else if (accept) offset_d = offset_q + 1'b1;

    if (accept) begin
      first_d = s_tlast;
      if (first_q) cur_flow_d = s_tdest;
    end
  end

  always_comb begin
    b_wen_d      = accept;
    b_waddr_d    = b_waddr_q;
    b_wdata_d    = b_wdata_q;
    used_valid_d = close;
    used_d       = used_q;
    used_flow_d  = used_flow_q;
    if (accept) begin
      b_waddr_d = {cur_seg_q, offset_q};
      b_wdata_d = s_tdata;
    end
    if (close) begin
      used_d      = {s_tlast, cur_seg_q};
      used_flow_d = flow_eff;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      next_seg_q   <= '0;
      next_valid_q <= 1'b0;
      cur_seg_q    <= '0;
      cur_valid_q  <= 1'b0;
      offset_q     <= '0;
      first_q      <= 1'b1;
      cur_flow_q   <= '0;
      b_wen_q      <= 1'b0;
      b_waddr_q    <= '0;
      b_wdata_q    <= '0;
      used_q       <= '0;
      used_valid_q <= 1'b0;
      used_flow_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      next_seg_q   <= next_seg_d;
      next_valid_q <= next_valid_d;
      cur_seg_q    <= cur_seg_d;
      cur_valid_q  <= cur_valid_d;
      offset_q     <= offset_d;
      first_q      <= first_d;
      cur_flow_q   <= cur_flow_d;
      b_wen_q      <= b_wen_d;
      b_waddr_q    <= b_waddr_d;
      b_wdata_q    <= b_wdata_d;
      used_q       <= used_d;
      used_valid_q <= used_valid_d;
      used_flow_q  <= used_flow_d;
    end
  end

  assign b_wen              = b_wen_q;
  assign b_waddr            = b_waddr_q;
  assign b_wdata            = b_wdata_q;
  assign used_pointer       = used_q;
  assign used_pointer_valid = used_valid_q;
  assign used_pointer_flow  = used_flow_q;
  assign free_level         = count_q;

  // Returning a segment that is still held locally would hand it out twice.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    push |-> ((count_q != FULL_LEVEL) || pop));
  a_freed_not_live: assert property (@(posedge clk) disable iff (!rstn)
    (init_done && freed_pointer_valid) |->
      (!(cur_valid_q && (freed_pointer == cur_seg_q)) &&
       !(next_valid_q && (freed_pointer == next_seg_q))));

endmodule

// File: tb/tb_buffer_write.sv
// Directed bench for buffer_write with 4-beat segments, 8 segments and 8 flows.

module tb_buffer_write;

  localparam int SegW  = 2;
  localparam int SegAw = 3;
  localparam int AddrW = SegAw + SegW;
  localparam int FlowW = 3;
  localparam int DataW = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DataW-1:0]  s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tlast = 1'b0;
  logic [FlowW-1:0]  s_tdest = '0;
  logic              s_tready;
  logic [SegAw-1:0]  freed_pointer = '0;
  logic              freed_pointer_valid = 1'b0;
  logic              b_wen;
  logic [AddrW-1:0]  b_waddr;
  logic [DataW-1:0]  b_wdata;
  logic [SegAw:0]    used_pointer;
  logic              used_pointer_valid;
  logic [FlowW-1:0]  used_pointer_flow;
  logic [SegAw:0]    free_level;
  logic              init_done;

  int checksTotal = 0;
  int checksPassed = 0;
  int stallCycles = 0;

  logic [AddrW-1:0] waddrQ[$];
  logic [DataW-1:0] wdataQ[$];
  logic [SegAw:0]   usedQ[$];
  logic [FlowW-1:0] flowQ[$];

  buffer_write #(
    .SEGMENT_SIZE_W(SegW),
    .BUF_SEG_AW(SegAw),
    .ADDR_WIDTH(AddrW),
    .FLOWS_W(FlowW),
    .DATA_W(DataW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tdest(s_tdest),
    .s_tready(s_tready),
    .freed_pointer(freed_pointer),
    .freed_pointer_valid(freed_pointer_valid),
    .b_wen(b_wen),
    .b_waddr(b_waddr),
    .b_wdata(b_wdata),
    .used_pointer(used_pointer),
    .used_pointer_valid(used_pointer_valid),
    .used_pointer_flow(used_pointer_flow),
    .free_level(free_level),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Record every RAM write and published pointer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (b_wen) begin
        waddrQ.push_back(b_waddr);
        wdataQ.push_back(b_wdata);
      end
      if (used_pointer_valid) begin
        usedQ.push_back(used_pointer);
        flowQ.push_back(used_pointer_flow);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [63:0] addrAt(input int i);
    if (i < waddrQ.size()) return 64'(waddrQ[i]);
    return {64{1'bx}};
  endfunction

  function automatic logic [63:0] dataAt(input int i);
    if (i < wdataQ.size()) return 64'(wdataQ[i]);
    return {64{1'bx}};
  endfunction

  function automatic logic [63:0] usedAt(input int i);
    if (i < usedQ.size()) return 64'(usedQ[i]);
    return {64{1'bx}};
  endfunction

  function automatic logic [63:0] flowAt(input int i);
    if (i < flowQ.size()) return 64'(flowQ[i]);
    return {64{1'bx}};
  endfunction

  task automatic clearQueues();
    waddrQ.delete();
    wdataQ.delete();
    usedQ.delete();
    flowQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    checkOutput({tag, "_b_wen"}, 64'(b_wen), 64'd0);
    checkOutput({tag, "_b_waddr"}, 64'(b_waddr), 64'd0);
    checkOutput({tag, "_b_wdata"}, 64'(b_wdata), 64'd0);
    checkOutput({tag, "_used_ptr"}, 64'(used_pointer), 64'd0);
    checkOutput({tag, "_used_valid"}, 64'(used_pointer_valid), 64'd0);
    checkOutput({tag, "_used_flow"}, 64'(used_pointer_flow), 64'd0);
    checkOutput({tag, "_free_level"}, 64'(free_level), 64'd0);
    checkOutput({tag, "_init_done"}, 64'(init_done), 64'd0);
  endtask

  // Hold reset, check idle outputs, release and time the init sequence.
  task automatic resetAndInit(input string tag);
    int cnt;
    @(negedge clk);
    rstn = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    freed_pointer_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs(tag);
    rstn = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!init_done && cnt < 20);
    checkOutput({tag, "_init_cycles"}, 64'(cnt), 64'd8);
    cnt = 0;
    while (!s_tready && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput({tag, "_tready_within_4"}, 64'(cnt <= 4), 64'd1);
    @(negedge clk);
  endtask

  // Offer one beat from a negedge and return on the negedge after it is accepted.
  task automatic applyStimulus(input logic [DataW-1:0] data, input logic [FlowW-1:0] dest, input logic last);
    int waits;
    waits = 0;
    s_tvalid = 1'b1;
    s_tdata = data;
    s_tdest = dest;
    s_tlast = last;
    while (!s_tready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    stallCycles += waits;
    if (!s_tready) checkOutput("accept_timeout", 64'(s_tready), 64'd1);
    else @(negedge clk);
  endtask

  initial begin
    int accepted;
    int cnt;

    // Init
    resetAndInit("init");
    repeat (2) @(negedge clk);
    checkOutput("init_free_level", 64'(free_level), 64'd6);
    checkOutput("init_tready_held", 64'(s_tready), 64'd1);

    // Short packet
    clearQueues();
    applyStimulus(16'hA000, 3'd5, 1'b0);
    applyStimulus(16'hA001, 3'd5, 1'b0);
    applyStimulus(16'hA002, 3'd5, 1'b1);
    s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("short_nwrites", 64'(waddrQ.size()), 64'd3);
    checkOutput("short_waddr0", addrAt(0), 64'd0);
    checkOutput("short_waddr1", addrAt(1), 64'd1);
    checkOutput("short_waddr2", addrAt(2), 64'd2);
    checkOutput("short_wdata2", dataAt(2), 64'hA002);
    checkOutput("short_nused", 64'(usedQ.size()), 64'd1);
    checkOutput("short_used", usedAt(0), 64'h8);
    checkOutput("short_flow", flowAt(0), 64'd5);

    // Multi-segment packet
    resetAndInit("multi");
    clearQueues();
    stallCycles = 0;
    for (int i = 0; i < 9; i++) applyStimulus(DataW'(16'h0100 + i), 3'd2, (i == 8));
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("multi_stalls", 64'(stallCycles), 64'd0);
    for (int i = 0; i < 9; i++) checkOutput($sformatf("multi_waddr%0d", i), addrAt(i), 64'(i));
    checkOutput("multi_nused", 64'(usedQ.size()), 64'd3);
    checkOutput("multi_used0", usedAt(0), 64'h0);
    checkOutput("multi_used1", usedAt(1), 64'h1);
    checkOutput("multi_used2", usedAt(2), 64'hA);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("multi_flow%0d", i), flowAt(i), 64'd2);

    // Exact boundary and flow lock, then a one-beat packet on a new flow
    resetAndInit("bound");
    clearQueues();
    applyStimulus(16'h0B00, 3'd6, 1'b0);
    applyStimulus(16'h0B01, 3'd1, 1'b0);
    applyStimulus(16'h0B02, 3'd1, 1'b0);
    applyStimulus(16'h0B03, 3'd1, 1'b1);
    s_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("bound_nused", 64'(usedQ.size()), 64'd1);
    checkOutput("bound_used", usedAt(0), 64'h8);
    checkOutput("bound_flow", flowAt(0), 64'd6);
    applyStimulus(16'h0C00, 3'd3, 1'b1);
    s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("bound_nused2", 64'(usedQ.size()), 64'd2);
    checkOutput("bound_used2", usedAt(1), 64'h9);
    checkOutput("bound_flow2", flowAt(1), 64'd3);
    checkOutput("bound_waddr5", addrAt(4), 64'd4);

    // Exhaustion and refill
    resetAndInit("exh");
    clearQueues();
    accepted = 0;
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    s_tdest = 3'd1;
    for (int i = 0; i < 45; i++) begin
      s_tdata = DataW'(i);
      if (s_tready) accepted++;
      @(negedge clk);
    end
    #1;
    checkOutput("exh_accepted", 64'(accepted), 64'd32);
    checkOutput("exh_tready_low", 64'(s_tready), 64'd0);
    checkOutput("exh_free_level", 64'(free_level), 64'd0);
    checkOutput("exh_nused", 64'(usedQ.size()), 64'd8);
    checkOutput("exh_used0", usedAt(0), 64'h0);
    checkOutput("exh_used7", usedAt(7), 64'h7);
    clearQueues();
    freed_pointer = 3'd3;
    freed_pointer_valid = 1'b1;
    @(negedge clk);
    freed_pointer_valid = 1'b0;
    cnt = 0;
    while (!s_tready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("exh_refill_within_3", 64'(cnt <= 3), 64'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("exh_nwrites", 64'(waddrQ.size()), 64'd1);
    checkOutput("exh_refill_waddr", addrAt(0), 64'd12);
    checkOutput("exh_free_after", 64'(free_level), 64'd0);

    // Reset mid-packet
    resetAndInit("mid");
    clearQueues();
    applyStimulus(16'h0D00, 3'd4, 1'b0);
    applyStimulus(16'h0D01, 3'd4, 1'b0);
    rstn = 1'b0;
    s_tvalid = 1'b0;
    #1;
    checkResetOutputs("midrst");
    resetAndInit("mid_reinit");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_no_used", 64'(usedQ.size()), 64'd0);
    clearQueues();
    @(negedge clk);
    applyStimulus(16'h0E00, 3'd4, 1'b1);
    s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_waddr", addrAt(0), 64'd0);
    checkOutput("mid_used", usedAt(0), 64'h8);
    checkOutput("mid_flow", flowAt(0), 64'd4);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
